// File: rtl/fabm_pkg.sv
// fabm_pkg: shared widths and types for the FABM final-adder front-end.
package fabm_pkg;
  localparam int FABM_ROW_W = 56;
  localparam int FABM_SPLIT = 17;
  localparam int FABM_HI_W  = FABM_ROW_W - FABM_SPLIT;
  localparam int FABM_TAG_W = 4;
  typedef logic [FABM_HI_W-1:0] fabm_hi_t;
endpackage

// File: rtl/fabm_pipe_ctl.sv
// fabm_pipe_ctl: two-stage valid/ready control with bubble-free enable chain, flush and occupancy.
module fabm_pipe_ctl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       s1_load,
  output logic       s2_load,
  output logic [1:0] occ
);
  logic s1_v_q, s2_v_q, s1_en, s2_en;
  always_comb begin
    s2_en     = !s2_v_q | out_ready;
    s1_en     = !s1_v_q | s2_en;
    in_ready  = s1_en;
    out_valid = s2_v_q;
    s1_load   = s1_en & in_valid & !flush;
    s2_load   = s2_en & s1_v_q & !flush;
    occ       = {1'b0, s1_v_q} + {1'b0, s2_v_q};
  end
  // flush wins over every transfer, including an input accepted this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else if (flush) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      if (s2_en) s2_v_q <= s1_v_q;
      if (s1_en) s1_v_q <= in_valid;
    end
  end
endmodule

// File: rtl/fabm_pg_stage.sv
// fabm_pg_stage: two-stage prop/gen/cin front-end feeding the CARRY4 chain of the FABM final adder.
// Build option TRUNC_LOW_EN: omit the low-part adder, product_low and cin read as 0.
module fabm_pg_stage
  import fabm_pkg::*;
#(
  parameter int ROW_W = FABM_ROW_W,
  parameter int SPLIT = FABM_SPLIT,
  parameter int TAG_W = FABM_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROW_W-1:0]       row_a,
  input  logic [ROW_W-1:0]       row_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_W-SPLIT-1:0] prop,
  output logic [ROW_W-SPLIT-1:0] gen,
  output logic                   cin,
  output logic [SPLIT-1:0]       product_low,
  output logic [TAG_W-1:0]       out_tag,
  output logic [1:0]             occ
);
  localparam int HI_W = ROW_W - SPLIT;
  logic             s1_load, s2_load;
  logic [ROW_W-1:0] a_q, b_q;
  logic [TAG_W-1:0] s1_tag_q, tag_q;
  logic [HI_W-1:0]  prop_q, prop_d, gen_q, gen_d;
  logic [SPLIT:0]   low_q, low_d;
  fabm_pipe_ctl u_ctl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .s1_load  (s1_load),
    .s2_load  (s2_load),
    .occ      (occ)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      s1_tag_q <= '0;
    end else if (s1_load) begin
      a_q      <= row_a;
      b_q      <= row_b;
      s1_tag_q <= in_tag;
    end
  end
  always_comb begin
    prop_d = a_q[ROW_W-1:SPLIT] ^ b_q[ROW_W-1:SPLIT];
    gen_d  = a_q[ROW_W-1:SPLIT];
  end
`ifdef TRUNC_LOW_EN
  assign low_d = '0;
`else
  // top bit of the widened sum is the carry into bit SPLIT
  assign low_d = {1'b0, a_q[SPLIT-1:0]} + {1'b0, b_q[SPLIT-1:0]};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prop_q <= '0;
      gen_q  <= '0;
      low_q  <= '0;
      tag_q  <= '0;
    end else if (s2_load) begin
      prop_q <= prop_d;
      gen_q  <= gen_d;
      low_q  <= low_d;
      tag_q  <= s1_tag_q;
    end
  end
  assign prop        = prop_q;
  assign gen         = gen_q;
  assign cin         = low_q[SPLIT];
  assign product_low = low_q[SPLIT-1:0];
  assign out_tag     = tag_q;
endmodule

// File: tb/tb_fabm_pg_stage.sv
// tb_fabm_pg_stage: directed scenarios plus a randomized run against a queue-based reference model.
module tb_fabm_pg_stage;
  import fabm_pkg::*;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [55:0]     row_a = '0, row_b = '0;
  logic [3:0]      in_tag = '0;
  logic            in_ready, out_valid, cin;
  logic [38:0]     prop, gen;
  logic [16:0]     product_low;
  logic [3:0]      out_tag;
  logic [1:0]      occ;
  int              n_tests = 0, n_fail = 0;
  typedef struct {logic [55:0] a; logic [55:0] b; logic [3:0] tag; int age;} item_t;
  item_t           mq[$];

  fabm_pg_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .row_a(row_a), .row_b(row_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .prop(prop), .gen(gen), .cin(cin), .product_low(product_low), .out_tag(out_tag), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] exp_low(input logic [55:0] a, input logic [55:0] b);
`ifdef TRUNC_LOW_EN
    return 18'd0;
`else
    return 18'((a % 56'h20000) + (b % 56'h20000));
`endif
  endfunction

  task automatic drain();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic send_one(input logic [55:0] a, input logic [55:0] b, input logic [3:0] t);
    row_a = a; row_b = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({out_valid, occ, in_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ctl got ov=%b occ=%0d ir=%b want ov=0 occ=0 ir=1", out_valid, occ, in_ready);
    end
    n_tests++;
    if ({prop, gen, cin, product_low, out_tag} !== '0) begin
      n_fail++; $display("FAIL reset_data got prop=%h gen=%h cin=%b low=%h tag=%h want all 0", prop, gen, cin, product_low, out_tag);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_low_carry();
    logic [17:0] lo;
    drain();
    lo = exp_low(56'h1FFFF, 56'h1);
    send_one(56'h000000_0001FFFF, 56'h1, 4'h5);
    n_tests++;
    if ({out_valid, cin, product_low, prop, gen, out_tag} !== {1'b1, lo[17], lo[16:0], 39'd0, 39'd0, 4'h5}) begin
      n_fail++; $display("FAIL low_carry got ov=%b cin=%b low=%h prop=%h gen=%h tag=%h want ov=1 cin=%b low=%h prop=0 gen=0 tag=5",
                         out_valid, cin, product_low, prop, gen, out_tag, lo[17], lo[16:0]);
    end
  endtask

  task automatic test_high_prop();
    drain();
    send_one(56'hFF_FFFF_FFFE_0000, 56'h0, 4'h6);
    n_tests++;
    if ({out_valid, prop, gen, cin, product_low} !== {1'b1, {39{1'b1}}, {39{1'b1}}, 1'b0, 17'd0}) begin
      n_fail++; $display("FAIL high_prop got ov=%b prop=%h gen=%h cin=%b low=%h want ov=1 prop/gen all ones cin=0 low=0",
                         out_valid, prop, gen, cin, product_low);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got[$];
    int nt = 1;
    drain();
    for (int c = 0; c < 16; c++) begin
      out_ready = (c >= 4);
      in_valid = (nt <= 4);
      in_tag = 4'(nt);
      row_a = {$urandom, $urandom}; row_b = {$urandom, $urandom};
      #2;
      if (c == 2 || c == 3) begin
        n_tests++;
        if ({occ, in_ready, out_valid, out_tag} !== {2'd2, 1'b0, 1'b1, 4'd1}) begin
          n_fail++; $display("FAIL backpressure_stall c=%0d got occ=%0d ir=%b ov=%b tag=%0d want occ=2 ir=0 ov=1 tag=1",
                             c, occ, in_ready, out_valid, out_tag);
        end
      end
      if (out_valid && out_ready) got.push_back(out_tag);
      if (in_valid && in_ready) nt++;
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL backpressure_count got %0d outputs want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got[i] !== 4'(i + 1)) begin
          n_fail++; $display("FAIL backpressure_order idx=%0d got tag %0d want %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_full_simul();
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'd10;
    tick();
    in_tag = 4'd11;
    tick();
    in_tag = 4'd12; out_ready = 1'b1;
    #1;
    n_tests++;
    if ({occ, in_ready, out_tag} !== {2'd2, 1'b1, 4'd10}) begin
      n_fail++; $display("FAIL full_simul_pre got occ=%0d ir=%b tag=%0d want occ=2 ir=1 tag=10", occ, in_ready, out_tag);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({occ, out_valid, out_tag} !== {2'd2, 1'b1, 4'd11}) begin
      n_fail++; $display("FAIL full_simul_post got occ=%0d ov=%b tag=%0d want occ=2 ov=1 tag=11", occ, out_valid, out_tag);
    end
    tick();
    n_tests++;
    if ({occ, out_valid, out_tag} !== {2'd1, 1'b1, 4'd12}) begin
      n_fail++; $display("FAIL full_simul_last got occ=%0d ov=%b tag=%0d want occ=1 ov=1 tag=12", occ, out_valid, out_tag);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'd1;
    tick();
    in_tag = 4'd2;
    tick();
    in_tag = 4'd9; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({occ, out_valid} !== {2'd0, 1'b0}) begin
      n_fail++; $display("FAIL flush_clear got occ=%0d ov=%b want occ=0 ov=0", occ, out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_drop got %0d outputs after flush want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [17:0] lo;
    logic exp_ov, exp_ir;
    item_t it;
    drain();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      row_a = {$urandom, $urandom};
      row_b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) row_a[16:0] = 17'h1FFFF;
      in_tag = 4'($urandom);
      #2;
      exp_ov = (mq.size() == 2) || (mq.size() == 1 && mq[0].age >= 1);
      exp_ir = (mq.size() < 2) || out_ready;
      n_tests++;
      if ({occ, out_valid, in_ready} !== {2'(mq.size()), exp_ov, exp_ir}) begin
        n_fail++; $display("FAIL rand_ctl c=%0d got occ=%0d ov=%b ir=%b want occ=%0d ov=%b ir=%b",
                           c, occ, out_valid, in_ready, mq.size(), exp_ov, exp_ir);
      end
      if (exp_ov) begin
        it = mq[0];
        lo = exp_low(it.a, it.b);
        n_tests++;
        if ({prop, gen, cin, product_low, out_tag} !== {fabm_hi_t'((it.a ^ it.b) >> 17), fabm_hi_t'(it.a >> 17), lo[17], lo[16:0], it.tag}) begin
          n_fail++; $display("FAIL rand_data c=%0d got prop=%h gen=%h cin=%b low=%h tag=%h want prop=%h gen=%h cin=%b low=%h tag=%h",
                             c, prop, gen, cin, product_low, out_tag, fabm_hi_t'((it.a ^ it.b) >> 17), fabm_hi_t'(it.a >> 17), lo[17], lo[16:0], it.tag);
        end
      end
      if (flush) mq.delete();
      else begin
        if (exp_ov && out_ready) void'(mq.pop_front());
        foreach (mq[i]) mq[i].age++;
        if (in_valid && exp_ir) mq.push_back('{row_a, row_b, in_tag, 0});
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    drain();
    row_a = 56'hFF_FFFF_FFFE_0000; row_b = 56'h0; in_valid = 1'b1; in_tag = 4'd3;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, occ, prop, gen} !== '0) begin
      n_fail++; $display("FAIL async_reset got ov=%b occ=%0d prop=%h gen=%h want all 0", out_valid, occ, prop, gen);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL async_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    tick();
    row_a = 56'h12_3456_789A_BCDE; row_b = 56'h0F_0F0F_0F0F_0F0F; in_tag = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_latency1 got ov=%b want 0 one cycle after accept", out_valid);
    end
    tick();
    n_tests++;
    if ({out_valid, prop, out_tag} !== {1'b1, fabm_hi_t'((56'h12_3456_789A_BCDE ^ 56'h0F_0F0F_0F0F_0F0F) >> 17), 4'd7}) begin
      n_fail++; $display("FAIL async_fresh got ov=%b prop=%h tag=%0d want ov=1 prop=%h tag=7", out_valid, prop, out_tag,
                         fabm_hi_t'((56'h12_3456_789A_BCDE ^ 56'h0F_0F0F_0F0F_0F0F) >> 17));
    end
  endtask

  initial begin
    test_reset();
    test_low_carry();
    test_high_prop();
    test_backpressure();
    test_full_simul();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
